// File: rtl/mips_shift_pkg.sv
// Shared encodings for the MIPS right-shift unit, its decoder and the EX-stage controller.
// SHIFT_RIGHT_ROTATE_EN enables decoding of op 2'b10 as ROTR.
package mips_shift_pkg;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROTR = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // 2'b11 is always SRL; 2'b10 falls back to SRL when rotate is not built in.
  function automatic op_e decode_op(input logic [1:0] op);
    op_e dec;
    case (op)
      2'b01:   dec = OP_SRA;
`ifdef SHIFT_RIGHT_ROTATE_EN
      2'b10:   dec = OP_ROTR;
`endif
      default: dec = OP_SRL;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/shr_step.sv
// Single combinational right-shift stage: shifts work by n (0..STEP) for the latched op.
// ROTR datapath only exists when SHIFT_RIGHT_ROTATE_EN is defined.
module shr_step
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_W   = 3
) (
  input  logic [WIDTH-1:0] work,
  input  logic [N_W-1:0]   n,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] srl_res;
  logic [WIDTH-1:0] sra_res;

  assign srl_res = work >> n;
  assign sra_res = WIDTH'($signed(work) >>> n);

`ifdef SHIFT_RIGHT_ROTATE_EN
  logic [WIDTH-1:0] rotr_res;

  // A left shift by WIDTH yields zero, so n == 0 needs no special case.
  assign rotr_res = (work >> n) | (work << (WIDTH - n));

  always_comb begin
    result = srl_res;
    if (op == OP_SRA) begin
      result = sra_res;
    end else if (op == OP_ROTR) begin
      result = rotr_res;
    end
  end
`else
  always_comb begin
    result = srl_res;
    if (op == OP_SRA) begin
      result = sra_res;
    end
  end
`endif

endmodule

// File: rtl/shift_right_iter.sv
// Multi-cycle right shifter (SRL/SRA, optional ROTR) that moves STEP bits per clock.
// Define SHIFT_RIGHT_ROTATE_EN to make op 2'b10 perform ROTR.
module shift_right_iter
  import mips_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);

  localparam int N_W = $clog2(STEP + 1);

  state_e               state;
  state_e               state_next;
  op_e                  op_q;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     step_result;
  logic [SHAMT_W-1:0]   remaining;
  logic [N_W-1:0]       step_n;
  logic                 last_step;

  assign last_step = (int'(remaining) <= STEP);

  // Never shift past what is left, so remaining cannot underflow.
  always_comb begin
    step_n = N_W'(STEP);
    if (last_step) begin
      step_n = N_W'(remaining);
    end
  end

  shr_step #(
    .WIDTH (WIDTH),
    .N_W   (N_W)
  ) u_shr_step (
    .work   (work),
    .n      (step_n),
    .op     (op_q),
    .result (step_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_next = (shamt_i == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_o = 1'b1;
        if (last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operands are captured on accept so the requester may change them right away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      remaining <= '0;
      op_q      <= OP_SRL;
      result_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            work      <= data_i;
            remaining <= shamt_i;
            op_q      <= decode_op(op_i);
            if (shamt_i == '0) begin
              result_o <= data_i;
            end
          end
        end
        ST_SHIFT: begin
          work      <= step_result;
          remaining <= remaining - SHAMT_W'(step_n);
          if (last_step) begin
            result_o <= step_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_iter.sv
// Scoreboard bench for shift_right_iter; override STEP to cover other step sizes.
// Expected ROTR behaviour follows SHIFT_RIGHT_ROTATE_EN.
module tb_shift_right_iter;

  parameter int STEP = 4;

  typedef struct {
    logic [31:0] result;
    int          latency;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] data_i = '0;
  logic [4:0]  shamt_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_count = 0;
  exp_t sb[$];

  shift_right_iter #(
    .WIDTH   (32),
    .SHAMT_W (5),
    .STEP    (STEP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .data_i   (data_i),
    .shamt_i  (shamt_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && done_o) done_count++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic [31:0] r;
    case (op)
      2'b01: r = 32'($signed(d) >>> s);
`ifdef SHIFT_RIGHT_ROTATE_EN
      2'b10: r = (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
`endif
      default: r = d >> s;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [4:0] s);
    return 1 + (int'(s) + STEP - 1) / STEP;
  endfunction

  // Drives one request in the next cycle, scrambles operands after accept, waits for done_o.
  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                        output logic [31:0] res, output int lat, output bit busy_ok,
                        output bit idle_ok, output exp_t e);
    exp_t pushed;
    @(negedge clk);
    idle_ok = !busy_o;
    start_i = 1'b1;
    op_i    = op;
    data_i  = d;
    shamt_i = s;
    pushed.result  = model(op, d, s);
    pushed.latency = exp_lat(s);
    sb.push_back(pushed);
    busy_ok = 1'b1;
    lat     = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        start_i = 1'b0;
        op_i    = 2'($urandom);
        data_i  = $urandom;
        shamt_i = 5'($urandom);
      end
      lat++;
      if (!busy_o) busy_ok = 1'b0;
    end while (!done_o && lat < 200);
    res = result_o;
    e   = sb.pop_front();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
    vectors++;
    if (done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done_o); end
    vectors++;
    if (result_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_result got %h want 0", result_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_srl();
    logic [1:0]  ops [5] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
    logic [31:0] dat [5] = '{32'h80000000, 32'hF0000000, 32'h00000100, 32'hFFFFFFFF, 32'hDEADBEEF};
    logic [4:0]  sh  [5] = '{5'd31, 5'd8, 5'd8, 5'd1, 5'd13};
    logic [31:0] res; int lat; bit bok, iok; exp_t e;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], dat[i], sh[i], res, lat, bok, iok, e);
      vectors++;
      if (res !== e.result) begin miscompares++; $display("[TB] FAIL srl_result[%0d] got %h want %h", i, res, e.result); end
      vectors++;
      if (lat !== e.latency) begin miscompares++; $display("[TB] FAIL srl_latency[%0d] got %0d want %0d", i, lat, e.latency); end
      vectors++;
      if (!bok) begin miscompares++; $display("[TB] FAIL srl_busy[%0d] got low want high while active", i); end
    end
  endtask

  task automatic test_sra();
    logic [31:0] dat [4] = '{32'h80000000, 32'h7FFFFFF0, 32'h12345678, 32'hC0000001};
    logic [4:0]  sh  [4] = '{5'd31, 5'd4, 5'd0, 5'd5};
    logic [31:0] res; int lat; bit bok, iok; exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op(2'b01, dat[i], sh[i], res, lat, bok, iok, e);
      vectors++;
      if (res !== e.result) begin miscompares++; $display("[TB] FAIL sra_result[%0d] got %h want %h", i, res, e.result); end
      vectors++;
      if (lat !== e.latency) begin miscompares++; $display("[TB] FAIL sra_latency[%0d] got %0d want %0d", i, lat, e.latency); end
      vectors++;
      if (!bok) begin miscompares++; $display("[TB] FAIL sra_busy[%0d] got low want high while active", i); end
    end
  endtask

  task automatic test_rotr();
    logic [31:0] dat [3] = '{32'h00000001, 32'h0000ABCD, 32'h80000001};
    logic [4:0]  sh  [3] = '{5'd1, 5'd16, 5'd31};
    logic [31:0] res; int lat; bit bok, iok; exp_t e;
    for (int i = 0; i < 3; i++) begin
      run_op(2'b10, dat[i], sh[i], res, lat, bok, iok, e);
      vectors++;
      if (res !== e.result) begin miscompares++; $display("[TB] FAIL rotr_result[%0d] got %h want %h", i, res, e.result); end
      vectors++;
      if (lat !== e.latency) begin miscompares++; $display("[TB] FAIL rotr_latency[%0d] got %0d want %0d", i, lat, e.latency); end
    end
  endtask

  task automatic test_ignored_start();
    int          dc0, cyc, got_cyc, lat_want;
    logic [31:0] res;
    exp_t        pushed, e;
    lat_want = exp_lat(5'd8);
    got_cyc  = -1;
    res      = '0;
    @(negedge clk);
    dc0     = done_count;
    start_i = 1'b1; op_i = 2'b00; data_i = 32'hF0000000; shamt_i = 5'd8;
    pushed.result = model(2'b00, 32'hF0000000, 5'd8);
    pushed.latency = lat_want;
    sb.push_back(pushed);
    for (cyc = 1; cyc <= lat_want + 4; cyc++) begin
      @(negedge clk);
      if (done_o) begin got_cyc = cyc; res = result_o; end
      if (cyc == 1 || cyc == lat_want) begin
        start_i = 1'b1; op_i = 2'b01; data_i = 32'hFFFFFFFF; shamt_i = 5'd4;
      end else begin
        start_i = 1'b0;
      end
    end
    e = sb.pop_front();
    vectors++;
    if (res !== e.result) begin miscompares++; $display("[TB] FAIL ignore_result got %h want %h", res, e.result); end
    vectors++;
    if (got_cyc !== e.latency) begin miscompares++; $display("[TB] FAIL ignore_latency got %0d want %0d", got_cyc, e.latency); end
    vectors++;
    if (done_count - dc0 !== 1) begin miscompares++; $display("[TB] FAIL ignore_done_pulses got %0d want 1", done_count - dc0); end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_idle_busy got %b want 0", busy_o); end
  endtask

  task automatic test_reset_abort();
    int dc0;
    logic [31:0] res; int lat; bit bok, iok; exp_t e;
    @(negedge clk);
    dc0 = done_count;
    start_i = 1'b1; op_i = 2'b00; data_i = 32'hABCD0000; shamt_i = 5'd20;
    @(negedge clk);
    start_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_busy_before got %b want 1", busy_o); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_o, done_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL abort_flags got %b want 00", {busy_o, done_o}); end
    vectors++;
    if (result_o !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_result got %h want 0", result_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if (done_count !== dc0) begin miscompares++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", done_count - dc0); end
    run_op(2'b00, 32'h00000100, 5'd8, res, lat, bok, iok, e);
    vectors++;
    if (res !== e.result) begin miscompares++; $display("[TB] FAIL abort_next_result got %h want %h", res, e.result); end
    vectors++;
    if (lat !== e.latency) begin miscompares++; $display("[TB] FAIL abort_next_latency got %0d want %0d", lat, e.latency); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3] = '{2'b01, 2'b00, 2'b01};
    logic [31:0] dat [3] = '{32'h87654321, 32'h0F0F0F0F, 32'h40000000};
    logic [4:0]  sh  [3] = '{5'd7, 5'd0, 5'd30};
    logic [31:0] res; int lat; bit bok, iok; exp_t e;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], dat[i], sh[i], res, lat, bok, iok, e);
      vectors++;
      if (!iok) begin miscompares++; $display("[TB] FAIL b2b_gap[%0d] got busy want idle after done", i); end
      vectors++;
      if (res !== e.result) begin miscompares++; $display("[TB] FAIL b2b_result[%0d] got %h want %h", i, res, e.result); end
      vectors++;
      if (lat !== e.latency) begin miscompares++; $display("[TB] FAIL b2b_latency[%0d] got %0d want %0d", i, lat, e.latency); end
    end
  endtask

  task automatic test_random();
    logic [31:0] res; int lat; bit bok, iok; exp_t e;
    logic [1:0] op; logic [31:0] d; logic [4:0] s;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom);
      d  = $urandom;
      s  = 5'($urandom);
      run_op(op, d, s, res, lat, bok, iok, e);
      vectors++;
      if (res !== e.result) begin miscompares++; $display("[TB] FAIL rand_result[%0d] op=%b d=%h s=%0d got %h want %h", i, op, d, s, res, e.result); end
      vectors++;
      if (lat !== e.latency) begin miscompares++; $display("[TB] FAIL rand_latency[%0d] got %0d want %0d", i, lat, e.latency); end
    end
  endtask

  initial begin
    $display("[TB] shift_right_iter bench, STEP=%0d", STEP);
    test_reset();
    test_srl();
    test_sra();
    test_rotr();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
